fpga_reset_responder: RTL and testbench
=======================================

FPGA_RESET_RESPONDER -- requirements
Module: fpga_reset_responder

Interface
REQ-001 SHALL provide parameter SYNC_STAGES, default 2: synchronizer depth for req_in, legal range 2..4.
REQ-002 SHALL provide parameter QUIESCE_TIMEOUT, default 100000: maximum QUIESCE wait in clk cycles, which is 1 ms at 100 MHz.
REQ-003 SHALL provide parameter TIMEOUT_WIDTH, default 32: width of the quiesce counter, ceil(log2(QUIESCE_TIMEOUT)) or more.
REQ-004 SHALL provide parameter RELEASE_HOLD, default 16: number of cycles fabric_reset is held after the request deasserts, legal range 1..255.
REQ-005 SHALL have port clk, input, 1 bit: single clock domain, fpga_clk_100 at top level.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-007 SHALL have port req_in, input, 1 bit: HPS-to-FPGA reset request, level, active-high, asynchronous to clk.
REQ-008 SHALL have port fabric_idle, input, 1 bit: fabric logic reports no outstanding transactions.
REQ-009 SHALL have port timeout_clr, input, 1 bit: single-cycle pulse that clears timeout_flag.
REQ-010 SHALL have port quiesce_req, output, 1 bit: asks fabric logic to stop issuing new transactions.
REQ-011 SHALL have port fabric_reset, output, 1 bit: active-high reset to fabric logic.
REQ-012 SHALL have port ack_out, output, 1 bit: acknowledge returned to the HPS.
REQ-013 SHALL have port timeout_flag, output, 1 bit: sticky flag, set when a quiesce ended by timeout.
REQ-014 SHALL have port reset_count, output, 8 bits: saturating count of completed reset cycles.

Function
REQ-015 SHALL pass req_in through a SYNC_STAGES flip-flop chain; the FSM SHALL use only the last stage (req_s).
REQ-016 SHALL implement FSM states IDLE, QUIESCE, ACTIVE and RELEASE; all outputs SHALL be registered, and no output SHALL depend combinationally on any input.
REQ-017 IDLE: quiesce_req=0, fabric_reset=0, ack_out=0; req_s=1 -> QUIESCE, with the quiesce counter cleared.
REQ-018 QUIESCE: quiesce_req=1, fabric_reset=0, ack_out=0; the counter SHALL increment by 1 per cycle.
REQ-019 QUIESCE transitions SHALL be checked in this priority order: req_s=0 -> IDLE (abort, no count); fabric_idle=1 -> ACTIVE; counter==QUIESCE_TIMEOUT-1 -> ACTIVE with timeout_flag set.
REQ-020 ACTIVE: quiesce_req=1, fabric_reset=1, ack_out=1; the FSM SHALL stay while req_s=1; req_s=0 -> RELEASE, with the hold counter cleared.
REQ-021 RELEASE: quiesce_req=0, fabric_reset=1, ack_out=0; the hold counter SHALL increment per cycle.
REQ-022 RELEASE transitions: req_s=1 -> ACTIVE with no re-quiesce and no count increment; otherwise hold counter==RELEASE_HOLD-1 -> IDLE with reset_count incremented.
REQ-023 reset_count SHALL saturate at 255 and SHALL NOT wrap.
REQ-024 Latency: with req_in rising before clk edge 1, quiesce_req SHALL be high after edge SYNC_STAGES+1.
REQ-025 Latency: fabric_idle=1 sampled at edge N in QUIESCE SHALL give fabric_reset=1 and ack_out=1 after edge N.
REQ-026 Latency: req_s falling sampled at edge M in ACTIVE SHALL give ack_out=0 after edge M, and fabric_reset=0 after edge M+RELEASE_HOLD.
REQ-027 If timeout_clr and a timeout set occur in the same cycle, the set SHALL win.
REQ-028 fabric_idle SHALL be ignored in IDLE, ACTIVE and RELEASE.
REQ-029 A req_in pulse shorter than the synchronizer sampling window MAY be missed; no spurious transition SHALL occur.

Reset
REQ-030 When reset=1 at a clk edge: FSM SHALL go to IDLE, synchronizer stages, both counters, timeout_flag and reset_count SHALL clear to 0, and quiesce_req, fabric_reset and ack_out SHALL be 0.
REQ-031 Reset asserted mid-operation, in any state, SHALL abort to IDLE on that edge with no partial release hold.
REQ-032 After reset deasserts with req_in still high, the responder SHALL restart at QUIESCE via the normal path of REQ-024.

Verification
REQ-033 Normal cycle: req_in=1; fabric_idle=1 three cycles after quiesce_req rises; req_in=0 after 50 cycles -> fabric_reset high for the ACTIVE period plus 16 cycles, ack_out high only during ACTIVE, reset_count=1, timeout_flag=0.
REQ-034 Timeout: QUIESCE_TIMEOUT=20, fabric_idle held 0 -> ACTIVE entered exactly 20 cycles after QUIESCE entry, timeout_flag=1; a later timeout_clr pulse -> timeout_flag=0.
REQ-035 Abort: req_in drops after 5 QUIESCE cycles -> quiesce_req=0 SYNC_STAGES+1 cycles later, fabric_reset never asserted, reset_count unchanged.
REQ-036 Re-request: req_in reasserts at RELEASE hold count 8 -> return to ACTIVE, ack_out=1, fabric_reset stays 1 throughout, reset_count unchanged until the final release.
REQ-037 Saturation and reset: 260 complete cycles -> reset_count=255; reset asserted in ACTIVE -> all outputs 0 on the next edge, reset_count=0.

Source files
------------

// File: rtl/fpga_reset_responder.sv
// ---------------------------------------------------------------------------
// fpga_reset_responder
//
// Handles an HPS-to-FPGA reset request. The request is synchronized into clk,
// the fabric is asked to quiesce, fabric reset is asserted once the fabric
// reports idle (or the quiesce wait times out), and reset is held for a fixed
// number of cycles after the request drops before returning to idle.
//
// Parameters
//   SYNC_STAGES     : synchronizer depth for req_in (2..4)
//   QUIESCE_TIMEOUT : maximum QUIESCE wait in clk cycles
//   TIMEOUT_WIDTH   : width of the quiesce counter
//   RELEASE_HOLD    : cycles fabric_reset is held after the request drops (1..255)
//
// Ports
//   clk          : single clock (fpga_clk_100 at top level)
//   reset        : synchronous, active-high
//   req_in       : reset request level from HPS, asynchronous to clk
//   fabric_idle  : fabric reports no outstanding transactions
//   timeout_clr  : one-cycle pulse clearing timeout_flag
//   quiesce_req  : asks fabric to stop issuing new transactions
//   fabric_reset : active-high reset to fabric logic
//   ack_out      : acknowledge back to the HPS
//   timeout_flag : sticky, set when a quiesce ended by timeout
//   reset_count  : saturating count of completed reset cycles
// ---------------------------------------------------------------------------
module fpga_reset_responder #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned QUIESCE_TIMEOUT = 100000,
  parameter int unsigned TIMEOUT_WIDTH   = 32,
  parameter int unsigned RELEASE_HOLD    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_in,
  input  logic       fabric_idle,
  input  logic       timeout_clr,
  output logic       quiesce_req,
  output logic       fabric_reset,
  output logic       ack_out,
  output logic       timeout_flag,
  output logic [7:0] reset_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUIESCE = 2'd1,
    ACTIVE  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [TIMEOUT_WIDTH-1:0] Q_LAST = TIMEOUT_WIDTH'(QUIESCE_TIMEOUT - 1);
  localparam logic [7:0]               H_LAST = 8'(RELEASE_HOLD - 1);

  state_t                   state;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     req_s;
  logic [TIMEOUT_WIDTH-1:0] q_cnt;
  logic [7:0]               h_cnt;

  // Request synchronizer; only the last stage is used by the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  // FSM with registered outputs: each output is updated on the transition
  // into the state that defines it, so no output sees an input combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      q_cnt        <= '0;
      h_cnt        <= '0;
      timeout_flag <= 1'b0;
      reset_count  <= '0;
      quiesce_req  <= 1'b0;
      fabric_reset <= 1'b0;
      ack_out      <= 1'b0;
    end else begin
      // A timeout set later in this block overrides a simultaneous clear.
      if (timeout_clr) begin
        timeout_flag <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (req_s) begin
            state       <= QUIESCE;
            q_cnt       <= '0;
            quiesce_req <= 1'b1;
          end
        end

        QUIESCE: begin
          q_cnt <= q_cnt + TIMEOUT_WIDTH'(1);
          if (!req_s) begin
            // Request withdrawn before reset was applied: no count.
            state       <= IDLE;
            quiesce_req <= 1'b0;
          end else if (fabric_idle) begin
            state        <= ACTIVE;
            fabric_reset <= 1'b1;
            ack_out      <= 1'b1;
          end else if (q_cnt == Q_LAST) begin
            state        <= ACTIVE;
            fabric_reset <= 1'b1;
            ack_out      <= 1'b1;
            timeout_flag <= 1'b1;
          end
        end

        ACTIVE: begin
          if (!req_s) begin
            state       <= RELEASE;
            h_cnt       <= '0;
            quiesce_req <= 1'b0;
            ack_out     <= 1'b0;
          end
        end

        RELEASE: begin
          h_cnt <= h_cnt + 8'd1;
          if (req_s) begin
            // Re-request during hold: fabric is still in reset, so go
            // straight back without another quiesce.
            state       <= ACTIVE;
            quiesce_req <= 1'b1;
            ack_out     <= 1'b1;
          end else if (h_cnt == H_LAST) begin
            state        <= IDLE;
            fabric_reset <= 1'b0;
            if (reset_count != 8'hFF) begin
              reset_count <= reset_count + 8'd1;
            end
          end
        end

        default: begin
          state        <= IDLE;
          quiesce_req  <= 1'b0;
          fabric_reset <= 1'b0;
          ack_out      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_reset_responder.sv
module tb_fpga_reset_responder;

  localparam int unsigned SYNC = 2;
  localparam int unsigned TMO  = 20;
  localparam int unsigned HOLD = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_in;
  logic       fabric_idle;
  logic       timeout_clr;
  logic       quiesce_req;
  logic       fabric_reset;
  logic       ack_out;
  logic       timeout_flag;
  logic [7:0] reset_count;

  fpga_reset_responder #(
    .SYNC_STAGES    (SYNC),
    .QUIESCE_TIMEOUT(TMO),
    .TIMEOUT_WIDTH  (32),
    .RELEASE_HOLD   (HOLD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_in      (req_in),
    .fabric_idle (fabric_idle),
    .timeout_clr (timeout_clr),
    .quiesce_req (quiesce_req),
    .fabric_reset(fabric_reset),
    .ack_out     (ack_out),
    .timeout_flag(timeout_flag),
    .reset_count (reset_count)
  );

  always #5 clk = ~clk;

  // cyc == number of rising edges seen so far
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    c;
    string nm;
    bit    q;
    bit    f;
    bit    a;
    bit    t;
    int    rc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   done  = 1'b0;

  // Sorted insert so the monitor always sees the earliest cycle first.
  function automatic void exp_at(int c, string nm, bit q, bit f, bit a, bit t, int rc);
    exp_t e;
    int   idx;
    e.c = c; e.nm = nm; e.q = q; e.f = f; e.a = a; e.t = t; e.rc = rc;
    idx = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].c > c) begin
        idx = i;
        break;
      end
    end
    sb.insert(idx, e);
  endfunction

  // Monitor: compares outputs at the falling edge of the expected cycle.
  always @(negedge clk) begin
    if (!done) begin
      while (sb.size() > 0 && sb[0].c <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        n_vec++;
        if (e.c < cyc) begin
          n_bad++;
          $display("FAIL %s: expectation for cycle %0d not checked in time (now %0d)", e.nm, e.c, cyc);
        end else if (quiesce_req !== e.q || fabric_reset !== e.f || ack_out !== e.a ||
                     timeout_flag !== e.t || reset_count !== 8'(e.rc)) begin
          n_bad++;
          $display("FAIL %s @cyc %0d: got q=%b f=%b a=%b t=%b rc=%0d, want q=%b f=%b a=%b t=%b rc=%0d",
                   e.nm, cyc, quiesce_req, fabric_reset, ack_out, timeout_flag, reset_count,
                   e.q, e.f, e.a, e.t, e.rc);
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic goto_cyc(int c);
    while (cyc < c) tick(1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    reset       = 1'b1;
    req_in      = 1'b0;
    fabric_idle = 1'b0;
    timeout_clr = 1'b0;
    tick(3);
    exp_at(cyc, "reset_state", 0, 0, 0, 0, 0);
    reset = 1'b0;

    // A: normal cycle
    b = cyc;
    exp_at(b + 2,  "A.pre",      0, 0, 0, 0, 0);
    exp_at(b + 3,  "A.quiesce",  1, 0, 0, 0, 0);
    exp_at(b + 6,  "A.wait",     1, 0, 0, 0, 0);
    exp_at(b + 7,  "A.active",   1, 1, 1, 0, 0);
    exp_at(b + 52, "A.hold_act", 1, 1, 1, 0, 0);
    exp_at(b + 53, "A.release",  0, 1, 0, 0, 0);
    exp_at(b + 68, "A.hold_end", 0, 1, 0, 0, 0);
    exp_at(b + 69, "A.idle",     0, 0, 0, 0, 1);
    req_in = 1'b1;
    goto_cyc(b + 6);  fabric_idle = 1'b1;
    goto_cyc(b + 50); req_in = 1'b0;
    goto_cyc(b + 70); fabric_idle = 1'b0;

    // B: quiesce timeout, clear coinciding with set, later clear
    b = cyc;
    exp_at(b + 3,  "B.quiesce",   1, 0, 0, 0, 1);
    exp_at(b + 22, "B.last_wait", 1, 0, 0, 0, 1);
    exp_at(b + 23, "B.timeout",   1, 1, 1, 1, 1);
    exp_at(b + 26, "B.release",   0, 1, 0, 1, 1);
    exp_at(b + 42, "B.idle",      0, 0, 0, 1, 2);
    exp_at(b + 45, "B.flag_held", 0, 0, 0, 1, 2);
    exp_at(b + 46, "B.flag_clr",  0, 0, 0, 0, 2);
    req_in = 1'b1;
    goto_cyc(b + 22); timeout_clr = 1'b1;
    goto_cyc(b + 23); timeout_clr = 1'b0; req_in = 1'b0;
    goto_cyc(b + 45); timeout_clr = 1'b1;
    goto_cyc(b + 46); timeout_clr = 1'b0;
    goto_cyc(b + 48);

    // C: abort during quiesce
    b = cyc;
    for (int k = 0; k <= 14; k++)
      exp_at(b + k, "C.abort", (k >= 3 && k < 11), 0, 0, 0, 2);
    req_in = 1'b1;
    goto_cyc(b + 8); req_in = 1'b0;
    goto_cyc(b + 15);

    // D: re-request at hold count 8
    b = cyc;
    for (int k = 0; k <= 50; k++)
      exp_at(b + k, "D.rereq",
             (k >= 3 && k < 13) || (k >= 22 && k < 33),
             (k >= 4 && k < 49),
             (k >= 4 && k < 13) || (k >= 22 && k < 33),
             0, (k >= 49) ? 3 : 2);
    req_in = 1'b1;
    goto_cyc(b + 3);  fabric_idle = 1'b1;
    goto_cyc(b + 10); req_in = 1'b0;
    goto_cyc(b + 19); req_in = 1'b1;
    goto_cyc(b + 30); req_in = 1'b0;
    goto_cyc(b + 51);

    // E: 260 back-to-back cycles, fabric_idle held high throughout
    for (int i = 0; i < 260; i++) begin
      b = cyc;
      exp_at(b + 4,  "E.active", 1, 1, 1, 0, (3 + i > 255) ? 255 : 3 + i);
      exp_at(b + 23, "E.count",  0, 0, 0, 0, (4 + i > 255) ? 255 : 4 + i);
      req_in = 1'b1;
      goto_cyc(b + 4); req_in = 1'b0;
      goto_cyc(b + 25);
    end

    // F: reset in ACTIVE with req_in held, restart, then reset in RELEASE
    b = cyc;
    exp_at(b + 4,  "F.active",      1, 1, 1, 0, 255);
    exp_at(b + 10, "F.pre_rst",     1, 1, 1, 0, 255);
    exp_at(b + 11, "F.rst_active",  0, 0, 0, 0, 0);
    exp_at(b + 13, "F.resync",      0, 0, 0, 0, 0);
    exp_at(b + 14, "F.requiesce",   1, 0, 0, 0, 0);
    exp_at(b + 15, "F.reactive",    1, 1, 1, 0, 0);
    exp_at(b + 18, "F.release",     0, 1, 0, 0, 0);
    exp_at(b + 20, "F.pre_rst2",    0, 1, 0, 0, 0);
    exp_at(b + 21, "F.rst_release", 0, 0, 0, 0, 0);
    exp_at(b + 25, "F.idle",        0, 0, 0, 0, 0);
    req_in = 1'b1;
    goto_cyc(b + 10); reset = 1'b1;
    goto_cyc(b + 11); reset = 1'b0;
    goto_cyc(b + 15); req_in = 1'b0;
    goto_cyc(b + 20); reset = 1'b1;
    goto_cyc(b + 21); reset = 1'b0;
    goto_cyc(b + 26);

    tick(3);
    done = 1'b1;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL %s: expectation for cycle %0d never checked", e.nm, e.c);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
